mmio_io_ctrl: RTL

Parametrised memory-mapped I/O controller for the pipelined CPU data-memory path. It provides:
- N writable and readable seven-segment digit registers with per-digit blanking.
- A switch port.
- Debounced push-buttons with level, sticky-edge and operator-select registers.
- A maskable interrupt.

It sits behind the data-memory address decoder. The decoder asserts write_enable only for I/O-space writes and passes the word address.

---
 rtl/mmio_io_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_io_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mmio_io_ctrl
//   Memory-mapped I/O block on the CPU data-memory path. It holds the
//   seven-segment digit registers, a synchronised switch port, debounced
//   push-buttons with level / sticky-edge / operator-select registers, and a
//   maskable key interrupt.
//
// Register map (word address):
//   0..NUM_HEX-1  HEX[i]     RW   [3:0] nibble, [4] blank (reset 5'h10)
//   16            SW         RO   synchronised switches
//   17            KEY_LEVEL  RO   debounced pressed state (1 = pressed)
//   18            KEY_EDGE   RW1C sticky press events
//   19            OPERATOR   RW   index of last accepted press
//   20            IRQ_MASK   RW   per-key interrupt enable
//   others        read 0, writes ignored
//
// Ports:
//   clock         system clock, all state on posedge
//   resetn        asynchronous active-low reset
//   addr          word address within I/O space
//   write_enable  store strobe (already qualified for I/O space)
//   datain        store data
//   dataout       registered load data, one cycle after addr
//   sw_in         raw switch levels (asynchronous)
//   key_in        raw push-buttons, active-low, bouncing
//   hex_out       active-low segments, digit i at [7i+6:7i] (gfe_dcba)
//   mode_led      one-hot decode of OPERATOR
//   irq           registered interrupt request
// -----------------------------------------------------------------------------
module mmio_io_ctrl #(
    parameter int NUM_HEX         = 6,
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [4:0]             addr,
    input  logic                   write_enable,
    input  logic [31:0]            datain,
    output logic [31:0]            dataout,
    input  logic [NUM_SW-1:0]      sw_in,
    input  logic [NUM_KEY-1:0]     key_in,
    output logic [7*NUM_HEX-1:0]   hex_out,
    output logic [NUM_KEY-1:0]     mode_led,
    output logic                   irq
);

    localparam int OP_W  = (NUM_KEY > 1) ? $clog2(NUM_KEY) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [4:0] ADDR_SW    = 5'd16;
    localparam logic [4:0] ADDR_LEVEL = 5'd17;
    localparam logic [4:0] ADDR_EDGE  = 5'd18;
    localparam logic [4:0] ADDR_OP    = 5'd19;
    localparam logic [4:0] ADDR_MASK  = 5'd20;

    // Active-low gfe_dcba glyphs; blank forces every segment off.
    function automatic logic [6:0] seg_decode(input logic [4:0] v);
        logic [6:0] seg;
        if (v[4]) begin
            seg = 7'b111_1111;
        end else begin
            case (v[3:0])
                4'h0:    seg = 7'b100_0000;
                4'h1:    seg = 7'b111_1001;
                4'h2:    seg = 7'b010_0100;
                4'h3:    seg = 7'b011_0000;
                4'h4:    seg = 7'b001_1001;
                4'h5:    seg = 7'b001_0010;
                4'h6:    seg = 7'b000_0010;
                4'h7:    seg = 7'b111_1000;
                4'h8:    seg = 7'b000_0000;
                4'h9:    seg = 7'b001_0000;
                4'hA:    seg = 7'b000_1000;
                4'hB:    seg = 7'b000_0011;
                4'hC:    seg = 7'b100_0110;
                4'hD:    seg = 7'b010_0001;
                4'hE:    seg = 7'b000_0110;
                default: seg = 7'b000_1110;
            endcase
        end
        return seg;
    endfunction

    logic [4:0]         hex_reg [NUM_HEX];
    logic [NUM_SW-1:0]  sw_p0, sw_p1;
    logic [NUM_KEY-1:0] key_p0, key_p1;
    logic [CNT_W-1:0]   db_cnt [NUM_KEY];
    logic [NUM_KEY-1:0] key_level;
    logic [NUM_KEY-1:0] key_edge;
    logic [NUM_KEY-1:0] irq_mask;
    logic [OP_W-1:0]    op_reg;

    logic [NUM_KEY-1:0] key_sample;
    logic [NUM_KEY-1:0] toggle;
    logic [NUM_KEY-1:0] press;
    logic [OP_W-1:0]    press_idx;
    logic [NUM_KEY-1:0] edge_clr;
    logic [31:0]        rdata;
    logic               unused_datain;

    assign unused_datain = ^datain;

    // ---- stage p0/p1: two-flop synchronisers (keys idle high when released)
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_p0  <= '0;
            sw_p1  <= '0;
            key_p0 <= '1;
            key_p1 <= '1;
        end else begin
            sw_p0  <= sw_in;
            sw_p1  <= sw_p0;
            key_p0 <= key_in;
            key_p1 <= key_p0;
        end
    end

    // ---- debounce / press detection (combinational on synchronised keys)
    assign key_sample = ~key_p1;

    always_comb begin
        toggle = '0;
        for (int k = 0; k < NUM_KEY; k++) begin
            toggle[k] = (key_sample[k] != key_level[k]) && (db_cnt[k] == CNT_LAST);
        end
    end

    assign press = toggle & ~key_level;

    // Scan downward so the lowest pressed index is the one that sticks.
    always_comb begin
        press_idx = '0;
        for (int k = NUM_KEY - 1; k >= 0; k--) begin
            if (press[k]) press_idx = OP_W'(k);
        end
    end

    assign edge_clr = (write_enable && addr == ADDR_EDGE) ? datain[NUM_KEY-1:0] : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_KEY; k++) db_cnt[k] <= '0;
            key_level <= '0;
        end else begin
            for (int k = 0; k < NUM_KEY; k++) begin
                if (key_sample[k] == key_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == CNT_LAST) begin
                    db_cnt[k]    <= '0;
                    key_level[k] <= ~key_level[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // ---- CPU-visible registers; a same-cycle press beats a CPU clear/write
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_HEX; i++) hex_reg[i] <= 5'h10;
            key_edge <= '0;
            irq_mask <= '0;
            op_reg   <= '0;
        end else begin
            for (int i = 0; i < NUM_HEX; i++) begin
                if (write_enable && addr == 5'(i)) hex_reg[i] <= datain[4:0];
            end
            key_edge <= (key_edge & ~edge_clr) | press;
            if (write_enable && addr == ADDR_MASK) irq_mask <= datain[NUM_KEY-1:0];
            if (|press) begin
                op_reg <= press_idx;
            end else if (write_enable && addr == ADDR_OP) begin
                op_reg <= datain[OP_W-1:0];
            end
        end
    end

    // ---- read mux, sampled from pre-write state
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (addr == 5'(i)) rdata[4:0] = hex_reg[i];
        end
        case (addr)
            ADDR_SW:    rdata[NUM_SW-1:0]  = sw_p1;
            ADDR_LEVEL: rdata[NUM_KEY-1:0] = key_level;
            ADDR_EDGE:  rdata[NUM_KEY-1:0] = key_edge;
            ADDR_OP:    rdata[OP_W-1:0]    = op_reg;
            ADDR_MASK:  rdata[NUM_KEY-1:0] = irq_mask;
            default:    ;
        endcase
    end

    // ---- output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dataout <= '0;
            irq     <= 1'b0;
        end else begin
            dataout <= rdata;
            irq     <= |(key_edge & irq_mask);
        end
    end

    always_comb begin
        mode_led = '0;
        for (int k = 0; k < NUM_KEY; k++) begin
            if (op_reg == OP_W'(k)) mode_led[k] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        assign hex_out[7*i +: 7] = seg_decode(hex_reg[i]);
    end

endmodule
